// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter with grant parking, lock and a stuck-slave watchdog.
// Latency: parked owner forwards combinationally (0 cycles); a grant switch adds 1 cycle.
// Backpressure: non-owner sees waitrequest=1; owner sees s_waitrequest, or 0 with busfault on abort.
module bus_arb2 #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    input  logic        m0_lock,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_busfault,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    input  logic        m1_lock,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_busfault,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    input  logic        s_busfault,
    output logic        owner
);

    // A zero TIMEOUT still needs a legal 1-bit counter; it simply never counts.
    localparam int             CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TMAX  = CW'(TIMEOUT);
    localparam bit             WD_ON = (TIMEOUT != 0);

    // Bus phase is decoded every cycle from the owner's strobes; owner and the
    // watchdog count are the only stored state.
    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_BUSY   = 2'd1,
        PH_LOCKED = 2'd2
    } phase_t;

    phase_t          phase;
    logic [CW-1:0]   wd_cnt;
    logic [CW-1:0]   wd_cnt_d;
    logic            owner_d;
    logic            own_rd;
    logic            own_wr;
    logic            own_lock;
    logic            own_req;
    logic            oth_req;
    logic            abort;
    logic            complete;
    logic            boundary;
    logic            flip;

    // Grant register and watchdog counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner  <= 1'b0;
            wd_cnt <= '0;
        end else begin
            owner  <= owner_d;
            wd_cnt <= wd_cnt_d;
        end
    end

    // Phase decode, boundary detection, next grant and next watchdog count.
    always_comb begin
        own_rd   = owner ? m1_read  : m0_read;
        own_wr   = owner ? m1_write : m0_write;
        own_lock = owner ? m1_lock  : m0_lock;
        own_req  = own_rd | own_wr;
        oth_req  = owner ? (m0_read | m0_write) : (m1_read | m1_write);

        abort    = WD_ON && own_req && (wd_cnt == TMAX);
        complete = own_req && (abort || !s_waitrequest);

        phase = PH_IDLE;
        if (own_req)
            phase = PH_BUSY;
        else if (own_lock)
            phase = PH_LOCKED;

        // The completion cycle itself belongs to BUSY; only an unlocked
        // completion (or a truly idle owner) lets the grant move.
        boundary = ((phase == PH_BUSY) && complete && !own_lock) ||
                   (phase == PH_IDLE);
        flip     = boundary && oth_req;
        owner_d  = owner ^ flip;

        wd_cnt_d = wd_cnt;
        if (!own_req || complete || flip)
            wd_cnt_d = '0;
        else if (WD_ON && s_waitrequest)
            wd_cnt_d = wd_cnt + CW'(1);
    end

    // Slave-side forwarding; strobes are suppressed during abort and reset so a
    // stuck or abandoned transfer is dropped rather than repeated.
    always_comb begin
        s_address    = owner ? m1_address    : m0_address;
        s_writedata  = owner ? m1_writedata  : m0_writedata;
        s_byteenable = owner ? m1_byteenable : m0_byteenable;
        s_read       = reset_n && own_rd && !abort;
        s_write      = reset_n && own_wr && !abort;
    end

    // Master-side responses: only the owner ever sees the slave's handshake.
    always_comb begin
        m0_readdata    = s_readdata;
        m1_readdata    = s_readdata;
        m0_waitrequest = !reset_n || owner  || (!abort && s_waitrequest);
        m1_waitrequest = !reset_n || !owner || (!abort && s_waitrequest);
        m0_busfault    = reset_n && !owner && (abort || s_busfault);
        m1_busfault    = reset_n &&  owner && (abort || s_busfault);
    end

endmodule

// File: tb/tb_bus_arb2.sv
// Directed bench for bus_arb2 with an 8-cycle watchdog.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
// Each scenario task compares against hand-derived expected values.
module tb_bus_arb2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_lock, m1_lock;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_busfault, m1_busfault;
    logic [31:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_busfault;
    logic        owner;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bus_arb2 #(.TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_busfault(m0_busfault),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_busfault(m1_busfault),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_busfault(s_busfault),
        .owner(owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        m0_address = '0; m1_address = '0;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_writedata = '0; m1_writedata = '0;
        m0_byteenable = 4'hF; m1_byteenable = 4'h3;
        m0_lock = 0; m1_lock = 0;
        s_waitrequest = 0; s_readdata = '0; s_busfault = 0;
        #1 reset_n = 1'b0;
        m0_read = 1; s_busfault = 1;
        #2;
        compared++;
        if (owner !== 1'b0) begin mismatched++; $display("FAIL reset_owner: got %b want 0", owner); end
        compared++;
        if (s_read !== 1'b0 || s_write !== 1'b0) begin mismatched++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0/0", s_read, s_write); end
        compared++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin mismatched++; $display("FAIL reset_wait: got m0=%b m1=%b want 1/1", m0_waitrequest, m1_waitrequest); end
        compared++;
        if (m0_busfault !== 1'b0 || m1_busfault !== 1'b0) begin mismatched++; $display("FAIL reset_fault: got m0=%b m1=%b want 0/0", m0_busfault, m1_busfault); end
        tick(); tick();
        compared++;
        if (owner !== 1'b0 || s_read !== 1'b0) begin mismatched++; $display("FAIL reset_hold: got owner=%b s_read=%b want 0/0", owner, s_read); end
        reset_n = 1'b1;
        m0_read = 0; s_busfault = 0;
    endtask

    task automatic test_parked_read();
        tick();
        m0_read = 1; m0_address = 32'h0000_0100; s_readdata = 32'hDEAD_BEEF;
        #2;
        compared++;
        if (s_read !== 1'b1 || s_address !== 32'h100) begin mismatched++; $display("FAIL parked_present: got s_read=%b addr=%h want 1/00000100", s_read, s_address); end
        compared++;
        if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL parked_complete: got wait=%b data=%h want 0/deadbeef", m0_waitrequest, m0_readdata); end
        compared++;
        if (m1_waitrequest !== 1'b1 || s_byteenable !== 4'hF) begin mismatched++; $display("FAIL parked_other: got m1_wait=%b be=%h want 1/f", m1_waitrequest, s_byteenable); end
        tick();
        m0_read = 0;
        #2;
        compared++;
        if (owner !== 1'b0 || m1_waitrequest !== 1'b1) begin mismatched++; $display("FAIL parked_after: got owner=%b m1_wait=%b want 0/1", owner, m1_waitrequest); end
    endtask

    task automatic test_switch();
        tick();
        m1_read = 1; m1_address = 32'h0000_3000;
        #2;
        compared++;
        if (owner !== 1'b0 || s_read !== 1'b0 || m1_waitrequest !== 1'b1) begin mismatched++; $display("FAIL switch_cycle: got owner=%b s_read=%b m1_wait=%b want 0/0/1", owner, s_read, m1_waitrequest); end
        tick();
        #2;
        compared++;
        if (owner !== 1'b1 || s_address !== 32'h3000 || s_read !== 1'b1) begin mismatched++; $display("FAIL switch_present: got owner=%b addr=%h rd=%b want 1/00003000/1", owner, s_address, s_read); end
        compared++;
        if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1 || s_byteenable !== 4'h3) begin mismatched++; $display("FAIL switch_wait: got m1=%b m0=%b be=%h want 0/1/3", m1_waitrequest, m0_waitrequest, s_byteenable); end
        tick();
        m1_read = 0;
        #2;
        compared++;
        if (owner !== 1'b1) begin mismatched++; $display("FAIL switch_park1: got %b want 1", owner); end
        tick();
        #2;
        compared++;
        if (owner !== 1'b1 || s_read !== 1'b0) begin mismatched++; $display("FAIL switch_park2: got owner=%b rd=%b want 1/0", owner, s_read); end
    endtask

    task automatic test_back_to_back();
        logic        exp_owner;
        logic [31:0] exp_addr;
        tick();
        m0_read = 1; m0_address = 32'h0000_0400;
        m1_read = 1; m1_address = 32'h0000_0500;
        for (int i = 0; i < 6; i++) begin
            #2;
            exp_owner = (i % 2 == 0);
            exp_addr  = exp_owner ? 32'h500 : 32'h400;
            compared++;
            if (owner !== exp_owner || s_address !== exp_addr) begin mismatched++; $display("FAIL b2b_owner[%0d]: got owner=%b addr=%h want %b/%h", i, owner, s_address, exp_owner, exp_addr); end
            compared++;
            if (m0_waitrequest !== exp_owner || m1_waitrequest !== !exp_owner) begin mismatched++; $display("FAIL b2b_wait[%0d]: got m0=%b m1=%b want %b/%b", i, m0_waitrequest, m1_waitrequest, exp_owner, !exp_owner); end
            tick();
        end
        m0_read = 0; m1_read = 0;
        #2;
        compared++;
        if (owner !== 1'b1) begin mismatched++; $display("FAIL b2b_end: got %b want 1", owner); end
    endtask

    task automatic test_lock();
        tick();
        m0_read = 1; m0_lock = 1; m0_address = 32'h0000_2000; s_waitrequest = 0;
        #2;
        compared++;
        if (owner !== 1'b1 || m0_waitrequest !== 1'b1) begin mismatched++; $display("FAIL lock_switch: got owner=%b m0_wait=%b want 1/1", owner, m0_waitrequest); end
        tick();
        m1_read = 1; m1_address = 32'h0000_0600; s_waitrequest = 1;
        #2;
        compared++;
        if (owner !== 1'b0 || s_read !== 1'b1 || s_address !== 32'h2000) begin mismatched++; $display("FAIL lock_rd_present: got owner=%b rd=%b addr=%h want 0/1/00002000", owner, s_read, s_address); end
        compared++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin mismatched++; $display("FAIL lock_rd_stall: got m0=%b m1=%b want 1/1", m0_waitrequest, m1_waitrequest); end
        tick();
        s_waitrequest = 0; s_readdata = 32'h1234_5678;
        #2;
        compared++;
        if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'h1234_5678) begin mismatched++; $display("FAIL lock_rd_done: got wait=%b data=%h want 0/12345678", m0_waitrequest, m0_readdata); end
        tick();
        m0_read = 0;
        #2;
        compared++;
        if (owner !== 1'b0 || s_read !== 1'b0 || m1_waitrequest !== 1'b1) begin mismatched++; $display("FAIL lock_gap: got owner=%b rd=%b m1_wait=%b want 0/0/1", owner, s_read, m1_waitrequest); end
        tick();
        m0_write = 1; m0_writedata = 32'hA5A5_5A5A; m0_lock = 0; s_waitrequest = 1;
        #2;
        compared++;
        if (owner !== 1'b0 || s_write !== 1'b1 || s_read !== 1'b0 || s_writedata !== 32'hA5A5_5A5A) begin mismatched++; $display("FAIL lock_wr_present: got owner=%b wr=%b rd=%b wd=%h want 0/1/0/a5a55a5a", owner, s_write, s_read, s_writedata); end
        tick();
        s_waitrequest = 0;
        #2;
        compared++;
        if (owner !== 1'b0 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin mismatched++; $display("FAIL lock_wr_done: got owner=%b m0=%b m1=%b want 0/0/1", owner, m0_waitrequest, m1_waitrequest); end
        tick();
        m0_write = 0;
        #2;
        compared++;
        if (owner !== 1'b1 || s_address !== 32'h600 || s_read !== 1'b1 || m1_waitrequest !== 1'b0) begin mismatched++; $display("FAIL lock_release: got owner=%b addr=%h rd=%b m1_wait=%b want 1/00000600/1/0", owner, s_address, s_read, m1_waitrequest); end
        tick();
        m1_read = 0;
    endtask

    task automatic test_timeout();
        tick();
        m0_read = 1; m0_address = 32'h0000_0700; s_waitrequest = 1;
        #2;
        compared++;
        if (owner !== 1'b1 || m0_waitrequest !== 1'b1) begin mismatched++; $display("FAIL to_switch: got owner=%b m0_wait=%b want 1/1", owner, m0_waitrequest); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin m1_read = 1; m1_address = 32'h0000_0800; end
            #2;
            compared++;
            if (m0_waitrequest !== 1'b1 || s_read !== 1'b1 || m0_busfault !== 1'b0 || m1_waitrequest !== 1'b1) begin mismatched++; $display("FAIL to_stall[%0d]: got m0_wait=%b rd=%b fault=%b m1_wait=%b want 1/1/0/1", i, m0_waitrequest, s_read, m0_busfault, m1_waitrequest); end
        end
        tick();
        #2;
        compared++;
        if (m0_busfault !== 1'b1 || m0_waitrequest !== 1'b0) begin mismatched++; $display("FAIL to_abort_resp: got fault=%b wait=%b want 1/0", m0_busfault, m0_waitrequest); end
        compared++;
        if (s_read !== 1'b0 || s_write !== 1'b0 || owner !== 1'b0 || m1_busfault !== 1'b0) begin mismatched++; $display("FAIL to_abort_gate: got rd=%b wr=%b owner=%b m1_fault=%b want 0/0/0/0", s_read, s_write, owner, m1_busfault); end
        tick();
        m0_read = 0; s_waitrequest = 0; s_readdata = 32'hCAFE_F00D;
        #2;
        compared++;
        if (owner !== 1'b1 || s_address !== 32'h800 || s_read !== 1'b1 || m1_waitrequest !== 1'b0) begin mismatched++; $display("FAIL to_regrant: got owner=%b addr=%h rd=%b m1_wait=%b want 1/00000800/1/0", owner, s_address, s_read, m1_waitrequest); end
    endtask

    task automatic test_busfault();
        tick();
        s_busfault = 1;
        #2;
        compared++;
        if (m1_busfault !== 1'b1 || m1_waitrequest !== 1'b0 || m0_busfault !== 1'b0) begin mismatched++; $display("FAIL bf_pass: got m1_fault=%b m1_wait=%b m0_fault=%b want 1/0/0", m1_busfault, m1_waitrequest, m0_busfault); end
        tick();
        m1_read = 0; s_busfault = 0;
        #2;
        compared++;
        if (owner !== 1'b1 || dut.wd_cnt !== 4'd0) begin mismatched++; $display("FAIL bf_after: got owner=%b cnt=%0d want 1/0", owner, dut.wd_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        tick();
        m1_read = 1; m1_address = 32'h0000_0900; s_waitrequest = 1;
        #2;
        compared++;
        if (owner !== 1'b1 || s_read !== 1'b1) begin mismatched++; $display("FAIL rst_stall_start: got owner=%b rd=%b want 1/1", owner, s_read); end
        tick();
        tick();
        #2;
        compared++;
        if (dut.wd_cnt !== 4'd2) begin mismatched++; $display("FAIL rst_stall_cnt: got %0d want 2", dut.wd_cnt); end
        #1 reset_n = 1'b0;
        #1;
        compared++;
        if (owner !== 1'b0 || s_read !== 1'b0 || dut.wd_cnt !== 4'd0) begin mismatched++; $display("FAIL rst_async: got owner=%b rd=%b cnt=%0d want 0/0/0", owner, s_read, dut.wd_cnt); end
        compared++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || m1_busfault !== 1'b0) begin mismatched++; $display("FAIL rst_async_resp: got m0=%b m1=%b m1_fault=%b want 1/1/0", m0_waitrequest, m1_waitrequest, m1_busfault); end
        m1_read = 0;
        tick();
        reset_n = 1'b1;
        tick();
        m0_read = 1; m0_address = 32'h0000_0A00; s_waitrequest = 0;
        #2;
        compared++;
        if (owner !== 1'b0 || s_read !== 1'b1 || s_address !== 32'hA00 || m0_waitrequest !== 1'b0) begin mismatched++; $display("FAIL rst_parked: got owner=%b rd=%b addr=%h wait=%b want 0/1/00000a00/0", owner, s_read, s_address, m0_waitrequest); end
        tick();
        m0_read = 0;
    endtask

    initial begin
        test_reset();
        test_parked_read();
        test_switch();
        test_back_to_back();
        test_lock();
        test_timeout();
        test_busfault();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
